// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receiver and its prescaler.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam logic [3:0] DATA_LEN_MIN = 4'd5;
  localparam logic [3:0] DATA_LEN_MAX = 4'd8;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len < DATA_LEN_MIN)      return DATA_LEN_MIN;
    else if (len > DATA_LEN_MAX) return DATA_LEN_MAX;
    else                         return len;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample prescaler: one-clock tick every baud+1 clocks, phase restarted by clear.
module uart_os_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [16:0] baud,
  output logic        tick
);

  logic [16:0] cnt;

  assign tick = !clear && (cnt == baud);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || cnt == baud) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 17'd1;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver with one-entry holding register.
// Optional break detection output enabled by defining UART_RX_BREAK_DETECT_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// RX_IDLE   | waiting for a synchronized falling edge; prescaler held
// RX_START  | start bit; majority 1 at bit end is a false start
// RX_DATA   | data bits, LSB first, written at their bit index
// RX_PARITY | parity bit compared against XOR of the data
// RX_STOP1  | first stop bit; completes at its mid-sample unless stop2
// RX_STOP2  | second stop bit; completes at its mid-sample
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int OS          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] baud,
  input  logic        en,
  input  logic        rx,
  input  logic        parity_en,
  input  logic        parity_type,
  input  logic [3:0]  data_len,
  input  logic        stop2,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic        break_det
`endif
);

  localparam int SW = $clog2(OS);
  localparam logic [SW-1:0] S_A   = SW'(OS/2 - 1);
  localparam logic [SW-1:0] S_B   = SW'(OS/2);
  localparam logic [SW-1:0] S_C   = SW'(OS/2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OS - 1);

  rx_state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_s, rx_prev, fall;
  logic tick, tick_clear;
  logic [SW-1:0] s_cnt;
  logic at_a, at_b, at_c, at_end;
  logic smp_a, smp_b, vote, bit_v;
  logic [2:0] bit_idx;
  logic [3:0] len_q;
  logic [7:0] data_q;
  logic par_en_q, par_type_q, stop2_q;
  logic perr_q, ferr_q;
  logic last_bit, is_break, exp_par;
  logic done_n, done_q, brk_n, accept;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign fall       = rx_prev & ~rx_s;
  assign tick_clear = (state == RX_IDLE);

  uart_os_tick u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .baud  (baud),
    .tick  (tick)
  );

  assign at_a   = tick && (s_cnt == S_A);
  assign at_b   = tick && (s_cnt == S_B);
  assign at_c   = tick && (s_cnt == S_C);
  assign at_end = tick && (s_cnt == S_END);

  // Third sample is taken live so the vote is ready on the same tick.
  assign vote     = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign last_bit = ({1'b0, bit_idx} == (len_q - 4'd1));
  assign exp_par  = (^data_q) ^ (par_type_q == PARITY_ODD);

`ifdef UART_RX_BREAK_DETECT_EN
  logic zero_q;
  assign is_break = zero_q & ~vote;
`else
  assign is_break = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= RX_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    brk_n   = 1'b0;
    case (state)
      RX_IDLE:   if (fall) state_n = RX_START;
      RX_START:  if (at_end) state_n = bit_v ? RX_IDLE : RX_DATA;
      RX_DATA:   if (at_end && last_bit) state_n = par_en_q ? RX_PARITY : RX_STOP1;
      RX_PARITY: if (at_end) state_n = RX_STOP1;
      RX_STOP1: begin
        if (at_c && is_break) begin
          brk_n   = 1'b1;
          state_n = RX_IDLE;
        end else if (at_c && !stop2_q) begin
          done_n  = 1'b1;
          state_n = RX_IDLE;
        end else if (at_end) begin
          state_n = RX_STOP2;
        end
      end
      RX_STOP2: begin
        if (at_c) begin
          done_n  = 1'b1;
          state_n = RX_IDLE;
        end
      end
      default: state_n = RX_IDLE;
    endcase
    if (!en) begin
      state_n = RX_IDLE;
      done_n  = 1'b0;
      brk_n   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_cnt      <= '0;
      smp_a      <= 1'b1;
      smp_b      <= 1'b1;
      bit_v      <= 1'b1;
      bit_idx    <= '0;
      len_q      <= DATA_LEN_MAX;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      done_q <= done_n;
      if (state == RX_IDLE) s_cnt <= '0;
      else if (tick)        s_cnt <= s_cnt + 1'b1;
      if (at_a) smp_a <= rx_s;
      if (at_b) smp_b <= rx_s;
      if (at_c) bit_v <= vote;

      // Frame config is frozen at the start edge.
      if (state == RX_IDLE && fall && en) begin
        len_q      <= clamp_len(data_len);
        par_en_q   <= parity_en;
        par_type_q <= parity_type;
        stop2_q    <= stop2;
        data_q     <= '0;
        bit_idx    <= '0;
        perr_q     <= 1'b0;
        ferr_q     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        zero_q     <= 1'b1;
`endif
      end

      if (state == RX_DATA) begin
        if (at_c) begin
          data_q[bit_idx] <= vote;
`ifdef UART_RX_BREAK_DETECT_EN
          if (vote) zero_q <= 1'b0;
`endif
        end
        if (at_end) bit_idx <= bit_idx + 3'd1;
      end

      if (state == RX_PARITY && at_c) begin
        perr_q <= vote ^ exp_par;
`ifdef UART_RX_BREAK_DETECT_EN
        if (vote) zero_q <= 1'b0;
`endif
      end

      if ((state == RX_STOP1 || state == RX_STOP2) && at_c) ferr_q <= ferr_q | ~vote;
    end
  end

  assign accept = rx_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done_q && (!rx_valid || accept)) begin
        rx_data    <= data_q;
        parity_err <= perr_q;
        frame_err  <= ferr_q;
        rx_valid   <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
      if (done_q && rx_valid && !accept) overrun <= 1'b1;
      else if (accept)                   overrun <= 1'b0;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  always_ff @(posedge clk) begin
    if (!rst) break_det <= 1'b0;
    else      break_det <= brk_n;
  end
`else
  // brk_n can never assert without break detection; tie it off here.
  logic unused_brk;
  assign unused_brk = brk_n;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed self-checking bench for uart_rx_os at baud = 3 (64 clk per bit).
module tb_uart_rx_os;

  localparam int BIT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] baud = 17'd3;
  logic        en = 1'b1;
  logic        rx = 1'b1;
  logic        parity_en = 1'b0;
  logic        parity_type = 1'b0;
  logic [3:0]  data_len = 4'd8;
  logic        stop2 = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic        parity_err;
  logic        frame_err;
  logic        overrun;
`ifdef UART_RX_BREAK_DETECT_EN
  logic        break_det;
`endif

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int brk_cnt = 0;
  logic [7:0] acc_data = '0;
  logic acc_perr = 1'b0;
  logic acc_ferr = 1'b0;

  uart_rx_os dut (
    .clk         (clk),
    .rst         (rst),
    .baud        (baud),
    .en          (en),
    .rx          (rx),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .data_len    (data_len),
    .stop2       (stop2),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun)
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    .break_det   (break_det)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      acc_cnt  = acc_cnt + 1;
      acc_data = rx_data;
      acc_perr = parity_err;
      acc_ferr = frame_err;
    end
`ifdef UART_RX_BREAK_DETECT_EN
    if (break_det) brk_cnt = brk_cnt + 1;
`endif
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 rx_ready = r;
  endtask

  task automatic send_frame(input logic [7:0] d, input int len, input logic pen,
                            input logic ptype, input logic st2, input logic flip_par,
                            input logic stop_bad, input int idle_bits);
    logic p;
    data_len    = 4'(len);
    parity_en   = pen;
    parity_type = ptype;
    stop2       = st2;
    p = ptype;
    for (int i = 0; i < len; i++) p = p ^ d[i];
    drive_bit(1'b0);
    for (int i = 0; i < len; i++) drive_bit(d[i]);
    if (pen) drive_bit(p ^ flip_par);
    drive_bit(!stop_bad);
    if (st2) drive_bit(1'b1);
    for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    rst = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic test_8n1();
    int n0;
    n0 = acc_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    total++; if (acc_cnt !== n0 + 1) begin bad++; $display("FAIL 8n1_count got=%0d exp=%0d", acc_cnt - n0, 1); end
    total++; if (acc_data !== 8'hA5) begin bad++; $display("FAIL 8n1_data got=%h exp=a5", acc_data); end
    total++; if (acc_perr !== 1'b0) begin bad++; $display("FAIL 8n1_perr got=%b exp=0", acc_perr); end
    total++; if (acc_ferr !== 1'b0) begin bad++; $display("FAIL 8n1_ferr got=%b exp=0", acc_ferr); end
  endtask

  task automatic test_7e2();
    int n0;
    n0 = acc_cnt;
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    total++; if (acc_data !== 8'h35) begin bad++; $display("FAIL 7e2_data got=%h exp=35", acc_data); end
    total++; if (acc_perr !== 1'b0) begin bad++; $display("FAIL 7e2_perr got=%b exp=0", acc_perr); end
    total++; if (acc_ferr !== 1'b0) begin bad++; $display("FAIL 7e2_ferr got=%b exp=0", acc_ferr); end
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    total++; if (acc_perr !== 1'b1) begin bad++; $display("FAIL 7e2_flip_perr got=%b exp=1", acc_perr); end
    total++; if (acc_cnt !== n0 + 2) begin bad++; $display("FAIL 7e2_count got=%0d exp=2", acc_cnt - n0); end
  endtask

  task automatic test_stop_err();
    int n0, b0;
    send_frame(8'h00, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    total++; if (acc_ferr !== 1'b1) begin bad++; $display("FAIL 8o1_ferr got=%b exp=1", acc_ferr); end
    total++; if (acc_data !== 8'h00) begin bad++; $display("FAIL 8o1_data got=%h exp=00", acc_data); end
    total++; if (acc_perr !== 1'b0) begin bad++; $display("FAIL 8o1_perr got=%b exp=0", acc_perr); end
    n0 = acc_cnt;
    b0 = brk_cnt;
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
`ifdef UART_RX_BREAK_DETECT_EN
    total++; if (brk_cnt !== b0 + 1) begin bad++; $display("FAIL break_pulse got=%0d exp=1", brk_cnt - b0); end
    total++; if (acc_cnt !== n0) begin bad++; $display("FAIL break_novalid got=%0d exp=0", acc_cnt - n0); end
`else
    total++; if (acc_cnt !== n0 + 1) begin bad++; $display("FAIL break_count got=%0d exp=1", acc_cnt - n0); end
    total++; if (acc_ferr !== 1'b1 || acc_data !== 8'h00 || brk_cnt !== b0) begin
      bad++; $display("FAIL break_frame got=%h/%b exp=00/1", acc_data, acc_ferr);
    end
`endif
  endtask

  task automatic test_glitch();
    int n0;
    n0 = acc_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    total++; if (acc_cnt !== n0) begin bad++; $display("FAIL glitch_none got=%0d exp=0", acc_cnt - n0); end
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    total++; if (acc_cnt !== n0 + 1) begin bad++; $display("FAIL glitch_next_count got=%0d exp=1", acc_cnt - n0); end
    total++; if (acc_data !== 8'h5A) begin bad++; $display("FAIL glitch_next_data got=%h exp=5a", acc_data); end
  endtask

  task automatic test_back_to_back();
    set_ready(1'b0);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", rx_valid); end
    total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL b2b_data got=%h exp=11", rx_data); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%b exp=1", overrun); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL b2b_ferr got=%b exp=0", frame_err); end
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_acc_valid got=%b exp=0", rx_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_acc_overrun got=%b exp=0", overrun); end
    set_ready(1'b1);
  endtask

  task automatic test_en_abort();
    int n0;
    n0 = acc_cnt;
    data_len = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    repeat (BIT / 2) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (8 * BIT) @(negedge clk);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    total++; if (acc_cnt !== n0 + 1) begin bad++; $display("FAIL en_abort_count got=%0d exp=1", acc_cnt - n0); end
    total++; if (acc_data !== 8'h3C) begin bad++; $display("FAIL en_abort_data got=%h exp=3c", acc_data); end
  endtask

  task automatic test_rst_abort();
    int n0;
    set_ready(1'b0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rst = 1'b0;
    @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_abort_valid got=%b exp=0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_abort_data got=%h exp=00", rx_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_abort_overrun got=%b exp=0", overrun); end
    rst = 1'b1;
    set_ready(1'b1);
    n0 = acc_cnt;
    repeat (8 * BIT) @(negedge clk);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    total++; if (acc_cnt !== n0 + 1) begin bad++; $display("FAIL rst_abort_count got=%0d exp=1", acc_cnt - n0); end
    total++; if (acc_data !== 8'h3C) begin bad++; $display("FAIL rst_abort_next got=%h exp=3c", acc_data); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_en_abort();
    test_rst_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
